decoder3x8_strobe: RTL and testbench

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It is the inverse of the 8-to-3 encoder in the combinational library. It accepts a 3-bit code and drives exactly one output line high for a fixed number of cycles. It sits where an encoded select must be turned back into timed one-hot strobes, such as line enables or chip selects.

---
 rtl/decoder3x8_strobe.sv | 141 ++++++++++++++
 tb/tb_decoder3x8_strobe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder3x8_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder3x8_strobe
//  Purpose  : Registered 3-to-8 one-hot decoder with a valid/ready input
//             handshake. Each accepted code drives exactly one line of y
//             high for HOLD_CYCLES clock cycles. A new code may be accepted
//             on the last hold cycle, so consecutive pulses run back-to-back
//             with no idle gap.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_CYCLES  cycles each decoded line stays high (1..255)
//    CNT_W        width of the saturating accepted-code counter
//  Ports
//    clk           in   1      rising-edge clock
//    rst           in   1      synchronous reset, active-high
//    en            in   1      enables acceptance of new codes
//    code_in       in   3      binary code to decode
//    code_valid    in   1      code_in is valid this cycle
//    code_ready    out  1      block accepts code_in this cycle
//    y             out  8      one-hot decoded output, zero when idle
//    y_valid       out  1      high while y is non-zero
//    busy          out  1      high while a pulse is being driven
//    accept_count  out  CNT_W  accepted codes, saturating at all-ones
// ============================================================================
module decoder3x8_strobe #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic [7:0]       y,
   output logic             y_valid,
   output logic             busy,
   output logic [CNT_W-1:0] accept_count
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Timer counts down the remaining hold cycles after the current one;
   // zero marks the last cycle of a pulse.
   localparam logic [7:0]       TIMER_RELOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_t           state_q, state_d;
   logic [7:0]       timer_q, timer_d;
   logic [7:0]       y_q,     y_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             ready_w;
   logic             accept_w;
   logic [7:0]       decoded_w;

   // Ready depends only on registered state and en, never on code_valid,
   // so the upstream may use it to form its own valid without a loop.
   // In IDLE the timer is always zero, but IDLE is named explicitly so the
   // intent does not rely on that invariant.
   assign ready_w   = en && ((state_q == ST_IDLE) || (timer_q == 8'd0));
   assign accept_w  = code_valid && ready_w;
   assign decoded_w = 8'd1 << code_in;

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      y_d     = y_q;
      count_d = count_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_w) begin
               y_d     = decoded_w;
               timer_d = TIMER_RELOAD;
               state_d = ST_DRIVE;
            end
         end

         ST_DRIVE: begin
            if (timer_q != 8'd0) begin
               // Mid-pulse: en going low cannot abort, the line stays up.
               timer_d = timer_q - 8'd1;
            end else if (accept_w) begin
               // Replacing y in one step keeps it one-hot across the switch.
               y_d     = decoded_w;
               timer_d = TIMER_RELOAD;
            end else begin
               y_d     = 8'd0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            y_d     = 8'd0;
            timer_d = 8'd0;
            state_d = ST_IDLE;
         end
      endcase

      if (accept_w && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // State registers; reset overrides any accept in the same cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= 8'd0;
         y_q     <= 8'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         y_q     <= y_d;
         count_q <= count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs, all derived from registered state except the handshake ready
   // ------------------------------------------------------------------------
   assign code_ready   = ready_w;
   assign y            = y_q;
   assign y_valid      = |y_q;
   assign busy         = (state_q == ST_DRIVE);
   assign accept_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder3x8_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder3x8_strobe
//  Purpose  : Directed self-checking bench. Three instances cover
//             HOLD_CYCLES=4, HOLD_CYCLES=1 and a 2-bit saturating counter.
//             Inputs change on the falling edge; outputs are checked 1 ns
//             after the falling edge, well away from the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder3x8_strobe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance A: HOLD_CYCLES=4, CNT_W=8 ----------------
   logic       a_rst = 1'b1, a_en = 1'b1, a_valid = 1'b0;
   logic [2:0] a_code = 3'd0;
   logic       a_ready, a_yv, a_busy;
   logic [7:0] a_y;
   logic [7:0] a_cnt;

   decoder3x8_strobe #(.HOLD_CYCLES(4), .CNT_W(8)) u_h4 (
      .clk(clk), .rst(a_rst), .en(a_en), .code_in(a_code),
      .code_valid(a_valid), .code_ready(a_ready), .y(a_y),
      .y_valid(a_yv), .busy(a_busy), .accept_count(a_cnt)
   );

   // ---------------- instance B: HOLD_CYCLES=1, CNT_W=8 ----------------
   logic       b_rst = 1'b1, b_en = 1'b1, b_valid = 1'b0;
   logic [2:0] b_code = 3'd0;
   logic       b_ready, b_yv, b_busy;
   logic [7:0] b_y;
   logic [7:0] b_cnt;

   decoder3x8_strobe #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
      .clk(clk), .rst(b_rst), .en(b_en), .code_in(b_code),
      .code_valid(b_valid), .code_ready(b_ready), .y(b_y),
      .y_valid(b_yv), .busy(b_busy), .accept_count(b_cnt)
   );

   // ---------------- instance C: HOLD_CYCLES=1, CNT_W=2 ----------------
   logic       c_rst = 1'b1, c_en = 1'b1, c_valid = 1'b0;
   logic [2:0] c_code = 3'd0;
   logic       c_ready, c_yv, c_busy;
   logic [7:0] c_y;
   logic [1:0] c_cnt;

   decoder3x8_strobe #(.HOLD_CYCLES(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(c_rst), .en(c_en), .code_in(c_code),
      .code_valid(c_valid), .code_ready(c_ready), .y(c_y),
      .y_valid(c_yv), .busy(c_busy), .accept_count(c_cnt)
   );

   int a_exp_cnt = 0;

   // Advance to 1 ns after the next falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      a_rst = 1'b1; a_en = 1'b1; a_valid = 1'b1; a_code = 3'd3;
      b_rst = 1'b1; c_rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (a_y !== 8'h00 || a_busy !== 1'b0 || a_yv !== 1'b0 || a_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state cyc%0d: y=%h busy=%b yv=%b cnt=%0d, want 00/0/0/0",
                     k, a_y, a_busy, a_yv, a_cnt);
         end
         total++;
         if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready cyc%0d: ready=%b, want 1", k, a_ready);
         end
      end
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      step(); // first edge after reset released: code 3 accepted
      a_exp_cnt = 1;
      total++;
      if (a_y !== 8'h08 || a_busy !== 1'b1 || a_yv !== 1'b1 || a_cnt !== 8'd1) begin
         bad++;
         $display("FAIL first_accept: y=%h busy=%b yv=%b cnt=%0d, want 08/1/1/1",
                  a_y, a_busy, a_yv, a_cnt);
      end
      a_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      total++;
      if (a_y !== 8'h00 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_drain: y=%h busy=%b, want 00/0", a_y, a_busy);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_single();
      a_en = 1'b1; a_code = 3'd5; a_valid = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_ready_idle: ready=%b, want 1", a_ready);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) a_valid = 1'b0;
         #1;
         total++;
         if (a_y !== 8'b0010_0000 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_y cyc%0d: y=%h busy=%b, want 20/1", k, a_y, a_busy);
         end
         total++;
         if (a_ready !== (k == 4)) begin
            bad++;
            $display("FAIL single_ready cyc%0d: ready=%b, want %0b", k, a_ready, (k == 4));
         end
      end
      a_exp_cnt++;
      step();
      total++;
      if (a_y !== 8'h00 || a_busy !== 1'b0 || a_yv !== 1'b0 || a_cnt !== 8'(a_exp_cnt)) begin
         bad++;
         $display("FAIL single_end: y=%h busy=%b yv=%b cnt=%0d, want 00/0/0/%0d",
                  a_y, a_busy, a_yv, a_cnt, a_exp_cnt);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [2:0] codes [3];
      logic [7:0] exp_y [3];
      codes[0] = 3'd0; codes[1] = 3'd7; codes[2] = 3'd2;
      exp_y[0] = 8'h01; exp_y[1] = 8'h80; exp_y[2] = 8'h04;
      a_en = 1'b1; a_code = codes[0]; a_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         // A code was just accepted at the start of each 4-cycle group.
         if (i % 4 == 0) begin
            if (i / 4 < 2) a_code = codes[i / 4 + 1];
            else a_valid = 1'b0;
         end
         total++;
         if (a_y !== exp_y[i / 4] || $countones(a_y) != 1) begin
            bad++;
            $display("FAIL b2b_y cyc%0d: y=%h, want %h", i, a_y, exp_y[i / 4]);
         end
      end
      a_exp_cnt += 3;
      step();
      total++;
      if (a_y !== 8'h00 || a_cnt !== 8'(a_exp_cnt)) begin
         bad++;
         $display("FAIL b2b_end: y=%h cnt=%0d, want 00/%0d", a_y, a_cnt, a_exp_cnt);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_sweep();
      b_en = 1'b1; b_code = 3'd0; b_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i < 7) b_code = 3'(i + 1);
         else b_valid = 1'b0;
         total++;
         if (b_y !== (8'd1 << i) || b_busy !== 1'b1 || b_ready !== 1'b1) begin
            bad++;
            $display("FAIL sweep_y cyc%0d: y=%h busy=%b ready=%b, want %h/1/1",
                     i, b_y, b_busy, b_ready, 8'd1 << i);
         end
      end
      step();
      total++;
      if (b_y !== 8'h00 || b_busy !== 1'b0 || b_cnt !== 8'd8) begin
         bad++;
         $display("FAIL sweep_end: y=%h busy=%b cnt=%0d, want 00/0/8", b_y, b_busy, b_cnt);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_en_drop();
      a_en = 1'b1; a_code = 3'd1; a_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) a_en = 1'b0;
         #1;
         total++;
         if (a_y !== 8'h02 || a_ready !== 1'b0) begin
            bad++;
            $display("FAIL endrop_y cyc%0d: y=%h ready=%b, want 02/0", k, a_y, a_ready);
         end
      end
      a_exp_cnt++;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (a_y !== 8'h00 || a_busy !== 1'b0 || a_ready !== 1'b0 || a_cnt !== 8'(a_exp_cnt)) begin
            bad++;
            $display("FAIL endrop_idle cyc%0d: y=%h busy=%b ready=%b cnt=%0d, want 00/0/0/%0d",
                     k, a_y, a_busy, a_ready, a_cnt, a_exp_cnt);
         end
      end
      a_en = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b1) begin
         bad++;
         $display("FAIL endrop_reenable: ready=%b, want 1", a_ready);
      end
      step();
      a_valid = 1'b0;
      a_exp_cnt++;
      total++;
      if (a_y !== 8'h02 || a_cnt !== 8'(a_exp_cnt)) begin
         bad++;
         $display("FAIL endrop_accept: y=%h cnt=%0d, want 02/%0d", a_y, a_cnt, a_exp_cnt);
      end
      for (int k = 0; k < 4; k++) step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid();
      a_en = 1'b1; a_code = 3'd6; a_valid = 1'b1;
      step();
      a_code = 3'd4; // still valid; would be accepted if not for reset
      total++;
      if (a_y !== 8'h40) begin
         bad++;
         $display("FAIL rstmid_pulse: y=%h, want 40", a_y);
      end
      step();
      a_rst = 1'b1; // cycle 2 of the pulse
      step();
      total++;
      if (a_y !== 8'h00 || a_busy !== 1'b0 || a_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rstmid_edge: y=%h busy=%b cnt=%0d, want 00/0/0", a_y, a_busy, a_cnt);
      end
      // ready is high in IDLE, valid is high: reset must still win
      step();
      total++;
      if (a_y !== 8'h00 || a_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rstmid_discard: y=%h cnt=%0d, want 00/0", a_y, a_cnt);
      end
      a_rst = 1'b0; a_valid = 1'b0;
      step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_saturation();
      c_en = 1'b1; c_valid = 1'b1; c_code = 3'd2;
      for (int k = 1; k <= 6; k++) begin
         step();
         c_code = 3'(k + 2);
         total++;
         if (c_cnt !== 2'((k < 3) ? k : 3) || c_y !== (8'd1 << ((k + 1) % 8))) begin
            bad++;
            $display("FAIL sat cyc%0d: cnt=%0d y=%h, want %0d/%h",
                     k, c_cnt, c_y, (k < 3) ? k : 3, 8'd1 << ((k + 1) % 8));
         end
      end
      c_valid = 1'b0;
      step();
      step();
      total++;
      if (c_cnt !== 2'd3 || c_y !== 8'h00) begin
         bad++;
         $display("FAIL sat_hold: cnt=%0d y=%h, want 3/00", c_cnt, c_y);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_sweep();
      test_en_drop();
      test_reset_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
